pipe_ctrl_unit: RTL and testbench

PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

---
 rtl/pipe_ctrl_unit.sv | 152 +++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit
// Pipeline control for a five-stage pipeline: turns hazard, fetch, branch and
// data-memory handshakes into register enables and bubble-insert flushes.
// A data-memory access that never completes escalates to a sticky error.
// Optional build macro: PIPE_CTRL_PERF_CNT_EN adds the stall and flush
// performance counters. Without it both counter outputs are tied to zero.

module pipe_ctrl_unit #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hzd_stall,
    input  logic        imem_ready,
    input  logic        branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_write,
    output logic        ex_mem_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_wb_flush,
    output logic        mem_err,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FIRST_WAIT = CNT_W'(1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] next_wait_cnt;
    logic             freeze;

    // Whole pipeline holds while the MEM stage waits on data memory or after a timeout
    assign freeze = ((state == RUN) && dmem_req && !dmem_ready) ||
                    ((state == MEM_WAIT) && !dmem_ready) ||
                    (state == ERR);

    // State register, wait counter and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_wait_cnt;
            mem_err  <= mem_err | (next_state == ERR);
        end
    end

    // Next-state logic: a ready in the same cycle as the timeout compare wins
    always_comb begin
        next_state    = state;
        next_wait_cnt = wait_cnt;
        unique case (state)
            RUN: begin
                if (dmem_req && !dmem_ready) begin
                    next_state    = MEM_WAIT;
                    next_wait_cnt = FIRST_WAIT;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    next_state    = RUN;
                    next_wait_cnt = '0;
                end else if (wait_cnt == LAST_WAIT) begin
                    next_state = ERR;
                end else begin
                    next_wait_cnt = wait_cnt + 1'b1;
                end
            end
            ERR: begin
                next_state = ERR;
            end
            default: begin
                next_state    = RUN;
                next_wait_cnt = '0;
            end
        endcase
    end

    // Output logic by priority: reset, freeze, branch redirect, load-use/fetch stall, run
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (hzd_stall || !imem_ready) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic branch_flush;

    assign branch_flush = !freeze && branch_taken;

    // Performance counters: cycles with the PC held, and branch-induced flushes; both wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_write) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (branch_flush) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed testbench for pipe_ctrl_unit, built with MEM_TIMEOUT=4.
// Inputs change on the falling edge; combinational outputs are sampled 1ns later,
// registered outputs reflect every rising edge before that point.

module tb_pipe_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hzd_stall = 1'b0;
    logic        imem_ready = 1'b1;
    logic        branch_taken = 1'b0;
    logic        dmem_req = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        pc_write;
    logic        if_id_write;
    logic        id_ex_write;
    logic        ex_mem_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        mem_wb_flush;
    logic        mem_err;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    int checks = 0;
    int errors = 0;
    int unsigned stallModel = 0;
    int unsigned flushModel = 0;

`ifdef PIPE_CTRL_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    // {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush, mem_wb_flush}
    localparam logic [6:0] NORMAL = 7'b1111_000;
    localparam logic [6:0] FREEZE = 7'b0000_001;
    localparam logic [6:0] BRANCH = 7'b1111_110;
    localparam logic [6:0] STALL  = 7'b0011_010;
    localparam logic [6:0] RESET  = 7'b0000_111;

    pipe_ctrl_unit #(.MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .hzd_stall    (hzd_stall),
        .imem_ready   (imem_ready),
        .branch_taken (branch_taken),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .id_ex_write  (id_ex_write),
        .ex_mem_write (ex_mem_write),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .mem_wb_flush (mem_wb_flush),
        .mem_err      (mem_err),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic h, input logic im,
                                 input logic br, input logic rq, input logic rd);
        @(negedge clk);
        rst          = r;
        hzd_stall    = h;
        imem_ready   = im;
        branch_taken = br;
        dmem_req     = rq;
        dmem_ready   = rd;
        #1;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ctrlBits();
        return {pc_write, if_id_write, id_ex_write, ex_mem_write,
                if_id_flush, id_ex_flush, mem_wb_flush};
    endfunction

    task automatic checkOutput(input string tag, input logic [6:0] expCtrl, input logic expErr);
        logic [31:0] expStall;
        logic [31:0] expFlush;
        expStall = PERF_ON ? stallModel : 32'd0;
        expFlush = PERF_ON ? flushModel : 32'd0;
        checkVal({tag, ".ctrl"}, {25'd0, ctrlBits()}, {25'd0, expCtrl});
        checkVal({tag, ".mem_err"}, {31'd0, mem_err}, {31'd0, expErr});
        checkVal({tag, ".stall_cycles"}, stall_cycles, expStall);
        checkVal({tag, ".flush_count"}, flush_count, expFlush);
        if (rst) begin
            stallModel = 0;
            flushModel = 0;
        end else begin
            if (!expCtrl[6]) stallModel++;
            if (expCtrl == BRANCH) flushModel++;
        end
    endtask

    // Directed sequence
    initial begin
        $display("[TB] start, PERF_ON=%0d", PERF_ON);

        // Reset: outputs forced regardless of state
        applyStimulus(1, 0, 1, 0, 0, 0);
        checkVal("reset0.ctrl", {25'd0, ctrlBits()}, {25'd0, RESET});
        applyStimulus(1, 1, 0, 1, 1, 0);
        checkOutput("reset1", RESET, 1'b0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("idle", NORMAL, 1'b0);

        // Load-use stall for one cycle, then fetch not ready
        applyStimulus(0, 1, 1, 0, 0, 0);
        checkOutput("loaduse", STALL, 1'b0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("loaduse_after", NORMAL, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("imem_wait", STALL, 1'b0);

        // Memory wait: 3 frozen cycles, release in the 4th, then back in RUN
        applyStimulus(0, 0, 1, 0, 1, 0);
        checkOutput("memwait1", FREEZE, 1'b0);
        applyStimulus(0, 0, 1, 0, 1, 0);
        checkOutput("memwait2", FREEZE, 1'b0);
        applyStimulus(0, 0, 1, 0, 1, 0);
        checkOutput("memwait3", FREEZE, 1'b0);
        applyStimulus(0, 0, 1, 0, 1, 1);
        checkOutput("memwait_release", NORMAL, 1'b0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("memwait_run", NORMAL, 1'b0);

        // Branch wins over load-use stall
        applyStimulus(0, 1, 1, 1, 0, 0);
        checkOutput("branch_prio", BRANCH, 1'b0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("branch_imem", BRANCH, 1'b0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("branch_after", NORMAL, 1'b0);

        // Redirect deferred through a 2-cycle memory wait
        applyStimulus(0, 0, 1, 1, 1, 0);
        checkOutput("defer1", FREEZE, 1'b0);
        applyStimulus(0, 0, 1, 1, 1, 0);
        checkOutput("defer2", FREEZE, 1'b0);
        applyStimulus(0, 0, 1, 1, 1, 1);
        checkOutput("defer_release", BRANCH, 1'b0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("defer_after", NORMAL, 1'b0);

        // Ready arriving exactly at the timeout compare avoids the error
        applyStimulus(0, 0, 1, 0, 1, 0);
        checkOutput("edge1", FREEZE, 1'b0);
        applyStimulus(0, 0, 1, 0, 1, 0);
        checkOutput("edge2", FREEZE, 1'b0);
        applyStimulus(0, 0, 1, 0, 1, 0);
        checkOutput("edge3", FREEZE, 1'b0);
        applyStimulus(0, 0, 1, 0, 1, 1);
        checkOutput("edge_release", NORMAL, 1'b0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("edge_after", NORMAL, 1'b0);

        // Timeout after 4 wait cycles; ERR ignores ready and branch
        applyStimulus(0, 0, 1, 0, 1, 0);
        checkOutput("tmo1", FREEZE, 1'b0);
        applyStimulus(0, 0, 1, 0, 1, 0);
        checkOutput("tmo2", FREEZE, 1'b0);
        applyStimulus(0, 0, 1, 0, 1, 0);
        checkOutput("tmo3", FREEZE, 1'b0);
        applyStimulus(0, 0, 1, 0, 1, 0);
        checkOutput("tmo4", FREEZE, 1'b0);
        applyStimulus(0, 0, 1, 0, 1, 1);
        checkOutput("err_ready", FREEZE, 1'b1);
        applyStimulus(0, 0, 1, 1, 0, 1);
        checkOutput("err_branch", FREEZE, 1'b1);

        // Reset clears ERR
        applyStimulus(1, 0, 1, 0, 0, 0);
        checkOutput("err_reset", RESET, 1'b1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("err_cleared", NORMAL, 1'b0);

        // Reset in the middle of a memory wait
        applyStimulus(0, 0, 1, 0, 1, 0);
        checkOutput("midwait1", FREEZE, 1'b0);
        applyStimulus(0, 0, 1, 0, 1, 0);
        checkOutput("midwait2", FREEZE, 1'b0);
        applyStimulus(1, 0, 1, 0, 1, 0);
        checkOutput("midwait_reset", RESET, 1'b0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("midwait_run", NORMAL, 1'b0);

        // Full wait sequence after reset still times out only at the 4th cycle
        applyStimulus(0, 0, 1, 0, 1, 0);
        checkOutput("post1", FREEZE, 1'b0);
        applyStimulus(0, 0, 1, 0, 1, 0);
        checkOutput("post2", FREEZE, 1'b0);
        applyStimulus(0, 0, 1, 0, 1, 0);
        checkOutput("post3", FREEZE, 1'b0);
        applyStimulus(0, 0, 1, 0, 0, 1);
        checkOutput("post_release", NORMAL, 1'b0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("post_after", NORMAL, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
